// File: rtl/fir_filter.sv
// Direct-form N-tap FIR: signed 16-bit samples in, registered signed 32-bit sum out.
// Optional macro FIR_SAT_EN saturates the wide sum to 32 bits instead of wrapping.
module fir_filter #(
   parameter int N = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] x_in,
   input  logic signed [15:0] coeffs [0:N-1],
   output logic signed [31:0] y_out
);

   localparam int ACC_W = 32 + $clog2(N);
   // With a single tap there is no history; keep one dummy stage held at zero.
   localparam int DL = (N > 1) ? (N - 1) : 1;

   localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(64'sd2147483647);
   localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'(-64'sd2147483648);

   logic signed [15:0]      d_q [0:DL-1];
   logic signed [15:0]      d_d [0:DL-1];
   logic signed [31:0]      y_q;
   logic signed [31:0]      y_d;
   logic signed [31:0]      prod_s;
   logic signed [ACC_W-1:0] acc_s;

   function automatic logic signed [31:0] reduce_sum(input logic signed [ACC_W-1:0] s);
`ifdef FIR_SAT_EN
      if (s > SUM_MAX) begin
         return SUM_MAX[31:0];
      end else if (s < SUM_MIN) begin
         return SUM_MIN[31:0];
      end else begin
         return s[31:0];
      end
`else
      return s[31:0];
`endif
   endfunction

   // Next delay-line contents and the full-precision tap sum.
   always_comb begin
      d_d[0] = (N > 1) ? x_in : 16'sd0;
      for (int k = 1; k < DL; k++) begin
         d_d[k] = d_q[k-1];
      end
      prod_s = 32'(coeffs[0]) * 32'(x_in);
      acc_s  = ACC_W'(prod_s);
      for (int i = 1; i < N; i++) begin
         prod_s = 32'(coeffs[i]) * 32'(d_q[i-1]);
         acc_s  = acc_s + ACC_W'(prod_s);
      end
      y_d = reduce_sum(acc_s);
   end

   // State registers; reset clears all history and the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DL; k++) begin
            d_q[k] <= 16'sd0;
         end
         y_q <= 32'sd0;
      end else begin
         for (int k = 0; k < DL; k++) begin
            d_q[k] <= d_d[k];
         end
         y_q <= y_d;
      end
   end

   assign y_out = y_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed self-checking bench for fir_filter (N=16); expectations hand-derived per step.
module tb_fir_filter;

   localparam int N = 16;

   logic               clk;
   logic               rst;
   logic signed [15:0] x_in;
   logic signed [15:0] coeffs [0:N-1];
   logic signed [31:0] y_out;

   int checks;
   int errors;

   fir_filter #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .x_in   (x_in),
      .coeffs (coeffs),
      .y_out  (y_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_all_coeffs(input logic signed [15:0] v);
      for (int i = 0; i < N; i++) coeffs[i] = v;
   endtask

   // Apply inputs, take one rising edge, then compare y_out just after it.
   task automatic tick_check(input logic r, input logic signed [15:0] x,
                             input logic signed [31:0] exp, input string tag);
      rst  = r;
      x_in = x;
      @(posedge clk);
      #1;
      checks++;
      assert (y_out === exp) else begin
         errors++;
         $error("FAIL %s: y_out=%0d expected %0d", tag, y_out, exp);
      end
   endtask

   initial begin
      logic signed [63:0] s;
      logic signed [31:0] e;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      x_in   = 16'sd0;
      for (int i = 0; i < N; i++) coeffs[i] = 16'($urandom);

      // Reset with random data present
      tick_check(1'b1, 16'($urandom), 32'sd0, "reset_edge0");
      for (int i = 0; i < N; i++) coeffs[i] = 16'($urandom);
      tick_check(1'b1, 16'($urandom), 32'sd0, "reset_edge1");
      tick_check(1'b0, 16'sd0, 32'sd0, "post_reset_zero0");
      tick_check(1'b0, 16'sd0, 32'sd0, "post_reset_zero1");

      // Impulse response: coeffs = 1..16
      for (int i = 0; i < N; i++) coeffs[i] = 16'(i + 1);
      tick_check(1'b0, 16'sd1, 32'sd1, "impulse_0");
      for (int j = 1; j <= 20; j++) begin
         tick_check(1'b0, 16'sd0, (j < N) ? 32'(j + 1) : 32'sd0, $sformatf("impulse_%0d", j));
      end

      // Step response: coeffs all 1, x=100
      set_all_coeffs(16'sd1);
      for (int k = 1; k <= 20; k++) begin
         tick_check(1'b0, 16'sd100, 32'(100 * ((k < N) ? k : N)), $sformatf("step_%0d", k));
      end

      // Mid-stream reset
      tick_check(1'b1, 16'sd100, 32'sd0, "mid_pre_reset");
      for (int k = 1; k <= 8; k++) begin
         tick_check(1'b0, 16'sd100, 32'(100 * k), $sformatf("mid_run_%0d", k));
      end
      tick_check(1'b1, 16'sd100, 32'sd0, "mid_reset");
      for (int k = 1; k <= 4; k++) begin
         tick_check(1'b0, 16'sd100, 32'(100 * k), $sformatf("mid_restart_%0d", k));
      end

      // Coefficient change takes effect on the next edge
      tick_check(1'b1, 16'sd0, 32'sd0, "coef_reset");
      for (int k = 1; k <= N; k++) begin
         tick_check(1'b0, 16'sd10, 32'(10 * k), $sformatf("coef_fill_%0d", k));
      end
      tick_check(1'b0, 16'sd10, 32'sd160, "coef_steady");
      set_all_coeffs(16'sd2);
      tick_check(1'b0, 16'sd10, 32'sd320, "coef_change");
      tick_check(1'b0, 16'sd10, 32'sd320, "coef_hold");

      // Overflow: each product is 2^30
      tick_check(1'b1, 16'sd0, 32'sd0, "ovf_reset");
      set_all_coeffs(-16'sd32768);
      for (int k = 1; k <= 20; k++) begin
         s = 64'sd1073741824 * 64'((k < N) ? k : N);
`ifdef FIR_SAT_EN
         e = (s > 64'sd2147483647) ? 32'sh7fffffff : s[31:0];
`else
         e = s[31:0];
`endif
         tick_check(1'b0, -16'sd32768, e, $sformatf("overflow_%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
